// File: rtl/trap_csr_unit_pkg.sv
// Shared definitions for the machine-mode trap/CSR unit: CSR map, bit
// positions, trap cause codes, CSR operation encodings and FSM states.
package trap_csr_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MIE_MTIE_BIT     = 7;
    localparam int unsigned MIE_MEIE_BIT     = 11;
    localparam int unsigned MIP_MTIP_BIT     = 7;
    localparam int unsigned MIP_MEIP_BIT     = 11;

    localparam logic [31:0] MCAUSE_EXT_IRQ   = 32'h8000_000B;
    localparam logic [31:0] MCAUSE_TIMER_IRQ = 32'h8000_0007;
    localparam logic [31:0] MCAUSE_ECALL     = 32'd11;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/trap_csr_unit_csr_alu.sv
// Combinational CSR update: write/set/clear of the old value, then masked
// down to the bits the addressed CSR actually implements.
module csr_alu
    import trap_csr_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  csr_op_e               op_i,
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] mask_i,
    output logic [DATA_WIDTH-1:0] new_o
);

    logic [DATA_WIDTH-1:0] raw;

    always_comb begin
        raw = old_i;
        unique case (op_i)
            CSR_OP_READ:  raw = old_i;
            CSR_OP_WRITE: raw = wdata_i;
            CSR_OP_SET:   raw = old_i | wdata_i;
            CSR_OP_CLEAR: raw = old_i & ~wdata_i;
            default:      raw = old_i;
        endcase
        new_o = raw & mask_i;
    end

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode trap state (mstatus/mie/mtvec/mepc/mcause) with a registered
// trap/return redirect to fetch over a valid/ready handshake.
module trap_csr_unit
    import trap_csr_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [31:0] MTVEC_RESET = 32'd100
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  ecall_i,
    input  logic                  mret_i,
    input  logic                  ext_irq_i,
    input  logic                  timer_irq_i,
    input  logic                  csr_we_i,
    input  logic [1:0]            csr_op_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [DATA_WIDTH-1:0] csr_wdata_i,
    output logic [DATA_WIDTH-1:0] csr_rdata_o,
    output logic [ADDR_WIDTH-1:0] mepc_o,
    output logic [ADDR_WIDTH-1:0] mtvec_o,
    output logic                  redirect_valid_o,
    output logic [ADDR_WIDTH-1:0] redirect_addr_o,
    input  logic                  redirect_ready_i
);

    state_e                state_q, state_d;
    logic                  mst_mie_q, mst_mie_d;
    logic                  mst_mpie_q, mst_mpie_d;
    logic                  mtie_q, mtie_d;
    logic                  meie_q, meie_d;
    logic [ADDR_WIDTH-1:0] mtvec_q, mtvec_d;
    logic [ADDR_WIDTH-1:0] mepc_q, mepc_d;
    logic [DATA_WIDTH-1:0] mcause_q, mcause_d;
    logic                  rvalid_q, rvalid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;

    logic [DATA_WIDTH-1:0] csr_mask;
    logic [DATA_WIDTH-1:0] alu_new;
    logic                  take_ext, take_timer, csr_wr;

    always_comb begin
        csr_rdata_o = '0;
        csr_mask    = '0;
        unique case (csr_addr_i)
            CSR_MSTATUS: begin
                csr_rdata_o[MSTATUS_MIE_BIT]  = mst_mie_q;
                csr_rdata_o[MSTATUS_MPIE_BIT] = mst_mpie_q;
                csr_mask[MSTATUS_MIE_BIT]     = 1'b1;
                csr_mask[MSTATUS_MPIE_BIT]    = 1'b1;
            end
            CSR_MIE: begin
                csr_rdata_o[MIE_MTIE_BIT] = mtie_q;
                csr_rdata_o[MIE_MEIE_BIT] = meie_q;
                csr_mask[MIE_MTIE_BIT]    = 1'b1;
                csr_mask[MIE_MEIE_BIT]    = 1'b1;
            end
            CSR_MTVEC: begin
                csr_rdata_o = DATA_WIDTH'(mtvec_q);
                csr_mask    = ~DATA_WIDTH'(3);
            end
            CSR_MEPC: begin
                csr_rdata_o = DATA_WIDTH'(mepc_q);
                csr_mask    = ~DATA_WIDTH'(3);
            end
            CSR_MCAUSE: begin
                csr_rdata_o = mcause_q;
                csr_mask    = '1;
            end
            CSR_MIP: begin
                // Read-only: mask stays zero so writes have no effect.
                csr_rdata_o[MIP_MTIP_BIT] = timer_irq_i;
                csr_rdata_o[MIP_MEIP_BIT] = ext_irq_i;
            end
            default: ;
        endcase
    end

    csr_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_csr_alu (
        .op_i    (csr_op_e'(csr_op_i)),
        .old_i   (csr_rdata_o),
        .wdata_i (csr_wdata_i),
        .mask_i  (csr_mask),
        .new_o   (alu_new)
    );

    assign take_ext   = ext_irq_i & meie_q & mst_mie_q;
    assign take_timer = timer_irq_i & mtie_q & mst_mie_q;
    assign csr_wr     = csr_we_i & (csr_op_e'(csr_op_i) != CSR_OP_READ);

    always_comb begin
        state_d    = state_q;
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mtie_d     = mtie_q;
        meie_d     = meie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        rvalid_d   = rvalid_q;
        raddr_d    = raddr_q;
        unique case (state_q)
            ST_IDLE: begin
                // Trap and MRET take priority; a concurrent CSR write is dropped.
                if (take_ext || take_timer || ecall_i) begin
                    mepc_d     = pc_i & ~ADDR_WIDTH'(3);
                    mcause_d   = take_ext   ? DATA_WIDTH'(MCAUSE_EXT_IRQ)   :
                                 take_timer ? DATA_WIDTH'(MCAUSE_TIMER_IRQ) :
                                              DATA_WIDTH'(MCAUSE_ECALL);
                    mst_mpie_d = mst_mie_q;
                    mst_mie_d  = 1'b0;
                    raddr_d    = mtvec_q;
                    rvalid_d   = 1'b1;
                    state_d    = ST_WAIT;
                end else if (mret_i) begin
                    mst_mie_d  = mst_mpie_q;
                    mst_mpie_d = 1'b1;
                    raddr_d    = mepc_q;
                    rvalid_d   = 1'b1;
                    state_d    = ST_WAIT;
                end else if (csr_wr) begin
                    unique case (csr_addr_i)
                        CSR_MSTATUS: begin
                            mst_mie_d  = alu_new[MSTATUS_MIE_BIT];
                            mst_mpie_d = alu_new[MSTATUS_MPIE_BIT];
                        end
                        CSR_MIE: begin
                            mtie_d = alu_new[MIE_MTIE_BIT];
                            meie_d = alu_new[MIE_MEIE_BIT];
                        end
                        CSR_MTVEC:  mtvec_d  = ADDR_WIDTH'(alu_new);
                        CSR_MEPC:   mepc_d   = ADDR_WIDTH'(alu_new);
                        CSR_MCAUSE: mcause_d = alu_new;
                        default: ;
                    endcase
                end
            end
            ST_WAIT: begin
                if (redirect_ready_i) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mtie_q     <= 1'b0;
            meie_q     <= 1'b0;
            mtvec_q    <= ADDR_WIDTH'(MTVEC_RESET);
            mepc_q     <= '0;
            mcause_q   <= '0;
            rvalid_q   <= 1'b0;
            raddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mtie_q     <= mtie_d;
            meie_q     <= meie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            rvalid_q   <= rvalid_d;
            raddr_q    <= raddr_d;
        end
    end

    assign mepc_o           = mepc_q;
    assign mtvec_o          = mtvec_q;
    assign redirect_valid_o = rvalid_q;
    assign redirect_addr_o  = raddr_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed plus randomized bench for trap_csr_unit against a CSR-level
// reference model of the trap/return/CSR rules.
`timescale 1ns/1ps
module tb_trap_csr_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        ecall, mret, ext, timer, we, ready;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata, mepc_o, mtvec_o, raddr_o;
    logic        rvalid_o;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic        m_mie, m_mpie, m_mtie, m_meie, m_busy;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_raddr;

    always #5 clk = ~clk;

    trap_csr_unit #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MTVEC_RESET (32'd100)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .pc_i             (pc),
        .ecall_i          (ecall),
        .mret_i           (mret),
        .ext_irq_i        (ext),
        .timer_irq_i      (timer),
        .csr_we_i         (we),
        .csr_op_i         (op),
        .csr_addr_i       (addr),
        .csr_wdata_i      (wdata),
        .csr_rdata_o      (rdata),
        .mepc_o           (mepc_o),
        .mtvec_o          (mtvec_o),
        .redirect_valid_o (rvalid_o),
        .redirect_addr_o  (raddr_o),
        .redirect_ready_i (ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mie = 0; m_mpie = 0; m_mtie = 0; m_meie = 0; m_busy = 0;
        m_mtvec = 32'd100; m_mepc = 0; m_mcause = 0; m_raddr = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: return (32'(m_meie) << 11) | (32'(m_mtie) << 7);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return (32'(ext) << 11) | (32'(timer) << 7);
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_trap(input logic [31:0] cause);
        m_mepc   = pc & 32'hFFFF_FFFC;
        m_mcause = cause;
        m_mpie   = m_mie;
        m_mie    = 0;
        m_raddr  = m_mtvec;
        m_busy   = 1;
    endtask

    task automatic m_write();
        logic [31:0] old, nv;
        old = m_read(addr);
        case (op)
            2'b01:   nv = wdata;
            2'b10:   nv = old | wdata;
            default: nv = old & ~wdata;
        endcase
        case (addr)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h304: begin m_mtie = nv[7]; m_meie = nv[11]; end
            12'h305: m_mtvec  = nv & 32'hFFFF_FFFC;
            12'h341: m_mepc   = nv & 32'hFFFF_FFFC;
            12'h342: m_mcause = nv;
            default: ;
        endcase
    endtask

    task automatic m_step();
        if (m_busy) begin
            if (ready) m_busy = 0;
        end else if (ext && m_meie && m_mie) m_trap(32'h8000_000B);
        else if (timer && m_mtie && m_mie) m_trap(32'h8000_0007);
        else if (ecall) m_trap(32'd11);
        else if (mret) begin
            m_mie   = m_mpie;
            m_mpie  = 1;
            m_raddr = m_mepc;
            m_busy  = 1;
        end else if (we && op != 2'b00) m_write();
    endtask

    // One clock: check the combinational read, advance the model, check state.
    task automatic cycle();
        @(negedge clk);
        check("rdata", rdata, m_read(addr));
        m_step();
        @(posedge clk);
        #1;
        check("valid", 32'(rvalid_o), 32'(m_busy));
        if (m_busy) check("raddr", raddr_o, m_raddr);
        check("mepc", mepc_o, m_mepc);
        check("mtvec", mtvec_o, m_mtvec);
    endtask

    task automatic read_check(input logic [11:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        #0.2;
        check(tag, rdata, exp);
    endtask

    task automatic csr_do(input logic [11:0] a, input logic [1:0] o, input logic [31:0] d);
        we = 1; op = o; addr = a; wdata = d;
        cycle();
        we = 0; op = 2'b00;
    endtask

    logic [11:0] addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h341,
                               12'h342, 12'h344, 12'h301, 12'h7C0};

    initial begin
        rst_n = 0; pc = 0; ecall = 0; mret = 0; ext = 0; timer = 0;
        we = 0; op = 0; addr = 0; wdata = 0; ready = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Reset state
        read_check(12'h305, 32'd100, "rst_mtvec");
        read_check(12'h300, 32'd0, "rst_mstatus");
        read_check(12'h341, 32'd0, "rst_mepc");
        read_check(12'h342, 32'd0, "rst_mcause");
        check("rst_valid", 32'(rvalid_o), 32'd0);

        // ECALL and handshake hold
        pc = 32'h40; ecall = 1;
        cycle();
        ecall = 0;
        check("ecall_valid", 32'(rvalid_o), 32'd1);
        check("ecall_addr", raddr_o, 32'd100);
        check("ecall_mepc", mepc_o, 32'h40);
        read_check(12'h342, 32'd11, "ecall_mcause");
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_valid", 32'(rvalid_o), 32'd1);
            check("hold_addr", raddr_o, 32'd100);
        end
        ready = 1;
        cycle();
        ready = 0;
        check("ready_drop", 32'(rvalid_o), 32'd0);

        // MRET, then ECALL ignored during WAIT
        csr_do(12'h300, 2'b10, 32'h8);
        csr_do(12'h304, 2'b10, 32'h800);
        mret = 1;
        cycle();
        mret = 0;
        check("mret_addr", raddr_o, 32'h40);
        read_check(12'h300, 32'h80, "mret_mstatus");
        ecall = 1; pc = 32'h88;
        cycle();
        ecall = 0;
        read_check(12'h342, 32'd11, "wait_ecall_ignored");
        ready = 1;
        cycle();
        ready = 0;

        // Priority: ext over timer over ecall
        csr_do(12'h300, 2'b10, 32'h8);
        csr_do(12'h304, 2'b10, 32'h80);
        pc = 32'h80; ext = 1; timer = 1; ecall = 1;
        cycle();
        ext = 0; timer = 0; ecall = 0;
        read_check(12'h342, 32'h8000_000B, "prio_mcause");
        read_check(12'h300, 32'h80, "prio_mstatus");
        check("prio_mepc", mepc_o, 32'h80);
        ready = 1;
        cycle();
        ready = 0;

        // CSR write masking and read-only mip
        csr_do(12'h341, 2'b01, 32'h123);
        read_check(12'h341, 32'h120, "mepc_mask");
        csr_do(12'h304, 2'b11, 32'h800);
        read_check(12'h304, 32'h80, "mie_clear");
        csr_do(12'h344, 2'b01, 32'hFFFF_FFFF);
        read_check(12'h344, 32'h0, "mip_ro");
        ext = 1;
        read_check(12'h344, 32'h800, "mip_ext");
        ext = 0;

        // Trap with concurrent mtvec write uses the old mtvec, write dropped
        ecall = 1; pc = 32'h10;
        csr_do(12'h305, 2'b01, 32'h200);
        ecall = 0;
        check("trap_old_mtvec", raddr_o, 32'd100);
        check("mtvec_write_dropped", mtvec_o, 32'd100);

        // Asynchronous reset while waiting
        #1 rst_n = 0;
        #0.5;
        m_reset();
        check("arst_valid", 32'(rvalid_o), 32'd0);
        check("arst_raddr", raddr_o, 32'd0);
        check("arst_mepc", mepc_o, 32'd0);
        check("arst_mtvec", mtvec_o, 32'd100);
        read_check(12'h342, 32'd0, "arst_mcause");
        #1 rst_n = 1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            pc    = $urandom() & 32'hFFFF_FFFC;
            ecall = ($urandom_range(0, 7) == 0);
            mret  = ($urandom_range(0, 7) == 0);
            ext   = ($urandom_range(0, 3) == 0);
            timer = ($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 1) == 1);
            we    = ($urandom_range(0, 1) == 1);
            op    = 2'($urandom_range(0, 3));
            addr  = addrs[$urandom_range(0, 7)];
            wdata = $urandom();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
- Machine-mode trap state holder; the CSR-side counterpart to the fetch-redirect logic.
- Accepts ECALL/MRET/interrupt events from decode and updates mepc, mcause and mstatus.
- Issues a registered redirect (trap vector or return address) to fetch through a valid/ready handshake.
- Serves CSR read/write from the execute stage; sits beside the register file and drives mepc_o to the existing redirect path.

Parameters:
- ADDR_WIDTH, 32, PC/address width.
- DATA_WIDTH, 32, CSR data width.
- MTVEC_RESET, 32'd100, mtvec value after reset.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- pc_i  in  ADDR_WIDTH  address of instruction currently in decode.
- ecall_i  in  1  decode sees ECALL.
- mret_i  in  1  decode sees MRET.
- ext_irq_i  in  1  external interrupt level.
- timer_irq_i  in  1  timer interrupt level.
- csr_we_i  in  1  CSR access strobe.
- csr_op_i  in  2  01 write, 10 set, 11 clear, 00 read-only.
- csr_addr_i  in  12  CSR address.
- csr_wdata_i  in  DATA_WIDTH  write/set/clear operand.
- csr_rdata_o  out  DATA_WIDTH  combinational read of csr_addr_i.
- mepc_o  out  ADDR_WIDTH  current mepc.
- mtvec_o  out  ADDR_WIDTH  current mtvec.
- redirect_valid_o  out  1  redirect request.
- redirect_addr_o  out  ADDR_WIDTH  redirect target.
- redirect_ready_i  in  1  fetch has flushed and taken the redirect.

Behaviour:
- Reset (async, rst_ni=0): mstatus=0, mie=0, mepc=0, mcause=0, mtvec=MTVEC_RESET, redirect_valid_o=0, redirect_addr_o=0, FSM=IDLE.
- CSR map:
  - mstatus 0x300: bit3 MIE, bit7 MPIE; other bits read 0.
  - mie 0x304: bit7 MTIE, bit11 MEIE.
  - mtvec 0x305: bits[1:0] forced 0.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342.
  - mip 0x344: read-only; bit7=timer_irq_i, bit11=ext_irq_i.
  - Unmapped addresses read 0 and ignore writes.
- Write ops:
  - write: new = wdata.
  - set: new = old | wdata.
  - clear: new = old & ~wdata.
  - Result is masked to the implemented bits.
- Event priority in IDLE, evaluated each cycle:
  - 1. External interrupt: ext_irq_i & MEIE & MIE, mcause=32'h8000000B.
  - 2. Timer interrupt: timer_irq_i & MTIE & MIE, mcause=32'h80000007.
  - 3. ECALL: mcause=32'd11.
  - 4. MRET.
- Trap entry (cases 1-3), at the clock edge:
  - mepc<=pc_i, mcause as above, MPIE<=MIE, MIE<=0.
  - redirect_addr_o<=mtvec; redirect_valid_o<=1; FSM->WAIT.
- MRET, at the clock edge: MIE<=MPIE, MPIE<=1, redirect_addr_o<=mepc, redirect_valid_o<=1, FSM->WAIT.
- Latency: an event sampled at edge N gives redirect_valid_o=1 after edge N.
- Simultaneous events:
  - ecall_i and mret_i both high: ECALL wins.
  - Trap/MRET in the same cycle as a CSR write: the CSR write is dropped.
  - CSR write to mtvec/mepc in the same cycle as a trap: the trap uses the pre-write value.
- WAIT state:
  - redirect_valid_o and redirect_addr_o are held stable.
  - All events and CSR writes are ignored; CSR reads still work.
  - When redirect_ready_i=1: redirect_valid_o<=0, FSM->IDLE.
- Interrupts are level-sensitive. An interrupt held high is retaken only after MRET restores MIE=1.
- Reset asserted mid-WAIT: immediate return to reset values; the outstanding redirect is dropped.
- In IDLE, redirect_valid_o stays 0 when no event occurs.

Decomposition:
- Shared package/defines holds:
  - CSR addresses.
  - mstatus/mie/mip bit indices.
  - mcause codes.
  - csr_op encodings.
  - FSM state encoding (IDLE, WAIT).
- One sub-module, csr_alu: combinational write/set/clear plus masking. All state stays in trap_csr_unit.

Test Plan:
- Reset, then read 0x305 -> 100; reads of 0x300/0x341/0x342 -> 0; redirect_valid_o=0.
- ecall_i=1 with pc_i=0x40 -> next cycle: redirect_valid_o=1, redirect_addr_o=100, mepc=0x40, mcause=11. Hold ready=0 for 3 cycles -> valid/addr stay stable; ready=1 -> valid drops next cycle.
- Set MIE and MEIE, then pulse mret_i -> redirect to mepc, MIE=MPIE; ecall_i issued during WAIT is ignored (mcause unchanged).
- ext_irq_i=1 with MIE=1, MEIE=1, together with timer_irq_i=1 (MTIE=1) and ecall_i=1 -> mcause=0x8000000B, MIE=0, MPIE=1.
- Write mepc=0x123 -> read 0x120. Clear op on mie with 0x800 -> MEIE=0, MTIE unchanged. Write to 0x344 -> mip unchanged.
- Assert rst_ni=0 during WAIT -> redirect_valid_o=0 immediately (asynchronous), all CSRs at reset values.
